// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable async serial receiver (5..8 data bits, N/O/E parity, 1/2 stop).
// Ports: clk, rstn, rx in; data/valid/parity_err/frame_err/overrun out; ready in.
module uart_rx_cfg #(
  parameter int BAUDDIV   = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(BAUDDIV);
  localparam logic [CW-1:0] FULL = CW'(BAUDDIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUDDIV / 2 - 1);
  localparam logic [2:0] LAST_D = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_S = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_nxt;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_val;
  logic          cnt_ld;
  logic          strobe;
  logic [2:0]    idx;
  logic          idx_clr;
  logic          frame_start;
  logic          shift_en;
  logic          par_en;
  logic          stop_en;
  logic          last_stop;
  logic [7:0]    sh;
  logic          pbit;
  logic          ferr_acc;
  logic          par_x;
  logic          perr_w;
  logic          ferr_w;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign strobe = (cnt == '0);

  always_comb begin
    state_nxt   = state;
    cnt_ld      = 1'b0;
    cnt_val     = FULL;
    idx_clr     = 1'b0;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    last_stop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_ld    = 1'b1;
          cnt_val   = HALF;
          state_nxt = START;
        end
      end
      START: begin
        if (strobe) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            cnt_ld      = 1'b1;
            idx_clr     = 1'b1;
            frame_start = 1'b1;
            state_nxt   = DATA;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shift_en = 1'b1;
          cnt_ld   = 1'b1;
          if (idx == LAST_D) begin
            idx_clr   = 1'b1;
            state_nxt = (PARITY != 0) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (strobe) begin
          par_en    = 1'b1;
          cnt_ld    = 1'b1;
          idx_clr   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          stop_en = 1'b1;
          if (idx == LAST_S) begin
            last_stop = 1'b1;
            state_nxt = rx_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt_ld = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      pbit     <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (cnt_ld) begin
        cnt <= cnt_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (idx_clr) begin
        idx <= '0;
      end else if (shift_en || stop_en) begin
        idx <= idx + 3'd1;
      end
      if (frame_start) begin
        sh       <= '0;
        ferr_acc <= 1'b0;
      end
      if (shift_en) sh[idx] <= rx_s;
      if (par_en) pbit <= rx_s;
      if (stop_en && !rx_s) ferr_acc <= 1'b1;
    end
  end

  assign par_x = (^sh) ^ pbit;

  always_comb begin
    perr_w = 1'b0;
    unique case (1'b1)
      (PARITY == 1): perr_w = ~par_x;
      (PARITY == 2): perr_w = par_x;
      default:       perr_w = 1'b0;
    endcase
  end

  // The final stop sample is still on rx_s at delivery time.
  assign ferr_w = ferr_acc | ~rx_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (last_stop) begin
      if (!valid || ready) begin
        data       <= sh;
        valid      <= 1'b1;
        parity_err <= perr_w;
        frame_err  <= ferr_w;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
